store_queue: RTL and testbench
==============================

// Module: store_queue
// PURPOSE
//  Posted-store buffer between the CPU memory stage and datamem (AXI single-beat writer).
//  - Accepts RV32I stores (SB/SH/SW), aligns data and builds byte strobes.
//  - Queues stores and replays them one at a time on datamem's WREN/WRADDR/WRSTRB/WRDATA port.
//  - Uses datamem's LOADING flag as back-pressure, so the CPU does not stall on AXI write latency.
// PARAMETERS
//  DEPTH_LOG2  2  log2 of queue depth; DEPTH = 2**DEPTH_LOG2 entries (4 by default)
// PORTS
//  CLK          in   1   clock
//  RST          in   1   reset, asynchronous, active-high
//  ST_VALID     in   1   store request from memory stage
//  ST_READY     out  1   queue can accept a store (count != DEPTH)
//  ST_ADDR      in   32  byte address of the store
//  ST_FUNCT3    in   3   000 SB, 001 SH, 010 SW; other codes are misaligned/illegal
//  ST_DATA      in   32  rs2 value, right-justified
//  ST_MISALIGN  out  1   1-cycle pulse: request rejected (bad align or bad funct3)
//  LD_ADDR      in   32  byte address of the load currently in the memory stage
//  LD_CONFLICT  out  1   load must stall: a pending store may alias it
//  SQ_EMPTY     out  1   queue empty, no WREN pending, LOADING low (fence/drain done)
//  WRADDR       out  32  word-aligned address to datamem
//  WREN         out  1   1-cycle write pulse to datamem
//  WRSTRB       out  4   byte strobes to datamem
//  WRDATA       out  32  lane-aligned data to datamem
//  LOADING      in   1   datamem busy (write FSM not idle or leaving idle)
// BEHAVIOUR
//  Reset (async): wr_ptr, rd_ptr and count go to 0; all entries are invalid.
//    WREN=0, WRADDR=0, WRSTRB=0, WRDATA=0, ST_MISALIGN=0.
//  Enqueue: occurs when ST_VALID && ST_READY && aligned; the entry is written at the rising edge.
//    SB: strb = 4'b0001<<a[1:0]; data = {4{d[7:0]}}.
//    SH: a[0] must be 0; strb = 4'b0011<<{a[1],1'b0}; data = {2{d[15:0]}}.
//    SW: a[1:0] must be 00; strb = 4'b1111; data = d.
//    Entry address = {a[31:2],2'b00}.
//  Reject: ST_VALID && ST_READY && misaligned/illegal. Nothing is enqueued.
//    ST_MISALIGN is registered and goes high in the next cycle for 1 cycle.
//  ST_READY depends only on count. A full queue refuses a store even if a dequeue happens in the same cycle.
//  Issue: WREN is a flop with next = !empty && !LOADING && !WREN.
//    - WRADDR, WRSTRB and WRDATA load the head entry on that same edge, and rd_ptr advances.
//    - LOADING is sampled only via the flop, so there is no combinational path LOADING->WREN.
//    - datamem raises LOADING combinationally while WREN=1; the !WREN term blocks a double issue.
//    - Back-to-back issue happens on the edge where LOADING falls.
//  Address/data outputs hold their last values when WREN=0.
//  Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. count is DEPTH_LOG2+1 bits.
//  Enqueue and issue in the same cycle leave count unchanged.
//  Store order is strictly FIFO. The bypass path (queue empty, store in, issue next edge) gives min latency of 1 cycle.
//  SQ_EMPTY = (count==0) && !WREN && !LOADING. It is combinational.
//  A reset mid-burst drops every queued store. datamem has its own reset.
// CONFIGURATION
//  STORE_SQ_FWD_EN defined:
//    LD_CONFLICT=1 iff some valid entry has addr[31:2]==LD_ADDR[31:2], or WREN=1 with WRADDR[31:2] matching.
//    The compare is combinational over all DEPTH entries. Non-aliasing loads proceed.
//  STORE_SQ_FWD_EN undefined:
//    LD_CONFLICT = !SQ_EMPTY. Any pending store stalls every load.
//    No per-entry compare logic is built.
// TESTING
//  1. SW 0x1000<-0xDEADBEEF, LOADING=0 -> next cycle WREN=1, WRADDR=0x1000, WRSTRB=F, WRDATA=0xDEADBEEF.
//  2. SB 0x1003<-0x12 -> WRSTRB=4'b1000, WRDATA=0x12121212.
//     SH 0x1002<-0xABCD -> WRSTRB=4'b1100, WRDATA=0xABCDABCD.
//  3. SH 0x1001 or SW 0x1002 -> ST_MISALIGN 1 cycle, no WREN, count unchanged.
//  4. Hold LOADING=1 and push 5 SW -> ST_READY=0 after 4. Release LOADING: 4 WREN pulses in FIFO order, never two consecutive.
//  5. Queue SW 0x2000, then load 0x2004 / 0x2000 -> with FWD_EN LD_CONFLICT 0/1; without FWD_EN 1/1.
//     After drain, SQ_EMPTY=1 and LD_CONFLICT=0.
//  6. Assert RST with 3 entries queued and WREN=1 -> all outputs 0 asynchronously, SQ_EMPTY=1 after release.

Source files
------------

// File: rtl/store_queue.sv
// Posted-store buffer: aligns RV32I stores, queues them and replays them one at a time to datamem.
// Build option: define STORE_SQ_FWD_EN for per-entry address compare on LD_CONFLICT.
module store_queue #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ST_VALID,
    output logic        ST_READY,
    input  logic [31:0] ST_ADDR,
    input  logic [2:0]  ST_FUNCT3,
    input  logic [31:0] ST_DATA,
    output logic        ST_MISALIGN,
    input  logic [31:0] LD_ADDR,
    output logic        LD_CONFLICT,
    output logic        SQ_EMPTY,
    output logic [31:0] WRADDR,
    output logic        WREN,
    output logic [3:0]  WRSTRB,
    output logic [31:0] WRDATA,
    input  logic        LOADING
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH-1:0]      ent_vld_q, ent_vld_d;
    logic [29:0]           ent_addr_q [DEPTH];
    logic [29:0]           ent_addr_d [DEPTH];
    logic [3:0]            ent_strb_q [DEPTH];
    logic [3:0]            ent_strb_d [DEPTH];
    logic [31:0]           ent_data_q [DEPTH];
    logic [31:0]           ent_data_d [DEPTH];

    logic        wren_q, wren_d;
    logic [31:0] wraddr_q, wraddr_d;
    logic [3:0]  wrstrb_q, wrstrb_d;
    logic [31:0] wrdata_q, wrdata_d;
    logic        misalign_q, misalign_d;

    logic        st_legal;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic        enq;
    logic        issue;
    logic        sq_empty;

    always_comb begin
        st_legal = 1'b0;
        st_strb  = 4'b0000;
        st_data  = 32'h0;
        case (ST_FUNCT3)
            3'b000: begin
                st_legal = 1'b1;
                st_strb  = 4'b0001 << ST_ADDR[1:0];
                st_data  = {4{ST_DATA[7:0]}};
            end
            3'b001: begin
                st_legal = !ST_ADDR[0];
                st_strb  = 4'b0011 << {ST_ADDR[1], 1'b0};
                st_data  = {2{ST_DATA[15:0]}};
            end
            3'b010: begin
                st_legal = (ST_ADDR[1:0] == 2'b00);
                st_strb  = 4'b1111;
                st_data  = ST_DATA;
            end
            default: st_legal = 1'b0;
        endcase
    end

    assign ST_READY = (count_q != FULL);
    assign enq      = ST_VALID && ST_READY && st_legal;
    // LOADING only reaches WREN through its flop; !wren_q covers the cycle before datamem reacts.
    assign issue    = (count_q != '0) && !LOADING && !wren_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ent_vld_d  = ent_vld_q;
        ent_addr_d = ent_addr_q;
        ent_strb_d = ent_strb_q;
        ent_data_d = ent_data_q;
        wren_d     = issue;
        wraddr_d   = wraddr_q;
        wrstrb_d   = wrstrb_q;
        wrdata_d   = wrdata_q;
        misalign_d = ST_VALID && ST_READY && !st_legal;

        if (issue) begin
            wraddr_d            = {ent_addr_q[rd_ptr_q], 2'b00};
            wrstrb_d            = ent_strb_q[rd_ptr_q];
            wrdata_d            = ent_data_q[rd_ptr_q];
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            ent_addr_d[wr_ptr_q] = ST_ADDR[31:2];
            ent_strb_d[wr_ptr_q] = st_strb;
            ent_data_d[wr_ptr_q] = st_data;
            ent_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        case ({enq, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ent_vld_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_strb_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrstrb_q   <= '0;
            wrdata_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ent_vld_q  <= ent_vld_d;
            ent_addr_q <= ent_addr_d;
            ent_strb_q <= ent_strb_d;
            ent_data_q <= ent_data_d;
            wren_q     <= wren_d;
            wraddr_q   <= wraddr_d;
            wrstrb_q   <= wrstrb_d;
            wrdata_q   <= wrdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign sq_empty    = (count_q == '0) && !wren_q && !LOADING;
    assign SQ_EMPTY    = sq_empty;
    assign WREN        = wren_q;
    assign WRADDR      = wraddr_q;
    assign WRSTRB      = wrstrb_q;
    assign WRDATA      = wrdata_q;
    assign ST_MISALIGN = misalign_q;

`ifdef STORE_SQ_FWD_EN
    logic ld_hit;

    always_comb begin
        ld_hit = wren_q && (wraddr_q[31:2] == LD_ADDR[31:2]);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_addr_q[i] == LD_ADDR[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign LD_CONFLICT = ld_hit;
`else
    // Without forwarding any pending store stalls every load, so the load address is not needed.
    logic ld_addr_unused;
    assign ld_addr_unused = ^LD_ADDR;
    assign LD_CONFLICT    = !sq_empty;
`endif

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios then random traffic against a queue-based reference model.
// Honours STORE_SQ_FWD_EN the same way as the design.
module tb_store_queue;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [2:0]  st_funct3;
    logic [31:0] st_data;
    logic        st_misalign;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        sq_empty;
    logic [31:0] wraddr;
    logic        wren;
    logic [3:0]  wrstrb;
    logic [31:0] wrdata;
    logic        loading;

    store_queue #(.DEPTH_LOG2(DL2)) dut (
        .CLK(clk), .RST(rst),
        .ST_VALID(st_valid), .ST_READY(st_ready), .ST_ADDR(st_addr),
        .ST_FUNCT3(st_funct3), .ST_DATA(st_data), .ST_MISALIGN(st_misalign),
        .LD_ADDR(ld_addr), .LD_CONFLICT(ld_conflict), .SQ_EMPTY(sq_empty),
        .WRADDR(wraddr), .WREN(wren), .WRSTRB(wrstrb), .WRDATA(wrdata),
        .LOADING(loading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_wren;
    logic [31:0] m_wraddr;
    logic [3:0]  m_wrstrb;
    logic [31:0] m_wrdata;
    logic        m_mis;

    int checks   = 0;
    int failures = 0;

    task automatic m_reset();
        mq.delete();
        m_wren   = 1'b0;
        m_wraddr = 32'h0;
        m_wrstrb = 4'h0;
        m_wrdata = 32'h0;
        m_mis    = 1'b0;
    endtask

    function automatic bit m_legal(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'd0:    return 1'b1;
            3'd1:    return (a % 2) == 0;
            3'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ent_t m_build(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.addr = a - (a % 4);
        if (f == 3'd0) begin
            e.strb = 4'(1 << (a % 4));
            e.data = (d & 32'hFF) * 32'h0101_0101;
        end else if (f == 3'd1) begin
            e.strb = 4'(3 << (a % 4));
            e.data = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.strb = 4'hF;
            e.data = d;
        end
        return e;
    endfunction

    function automatic bit m_empty();
        return (mq.size() == 0) && !m_wren && !loading;
    endfunction

    function automatic bit m_conflict();
`ifdef STORE_SQ_FWD_EN
        bit hit;
        hit = m_wren && ((m_wraddr >> 2) == (ld_addr >> 2));
        foreach (mq[i]) if ((mq[i].addr >> 2) == (ld_addr >> 2)) hit = 1'b1;
        return hit;
`else
        return !m_empty();
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":WREN"},        32'(wren),        32'(m_wren));
        chk({tag, ":WRADDR"},      wraddr,           m_wraddr);
        chk({tag, ":WRSTRB"},      32'(wrstrb),      32'(m_wrstrb));
        chk({tag, ":WRDATA"},      wrdata,           m_wrdata);
        chk({tag, ":ST_MISALIGN"}, 32'(st_misalign), 32'(m_mis));
        chk({tag, ":ST_READY"},    32'(st_ready),    32'(mq.size() != DEPTH));
        chk({tag, ":SQ_EMPTY"},    32'(sq_empty),    32'(m_empty()));
        chk({tag, ":LD_CONFLICT"}, 32'(ld_conflict), 32'(m_conflict()));
    endtask

    // One clock: model consumes the inputs present at the edge, then everything is compared.
    task automatic cycle(input string tag);
        bit   ready;
        bit   legal;
        bit   iss;
        ent_t e;
        ready = (mq.size() != DEPTH);
        legal = m_legal(st_funct3, st_addr);
        iss   = (mq.size() != 0) && !loading && !m_wren;
        e     = m_build(st_funct3, st_addr, st_data);
        @(posedge clk);
        #1;
        m_wren = iss;
        if (iss) begin
            m_wraddr = mq[0].addr;
            m_wrstrb = mq[0].strb;
            m_wrdata = mq[0].data;
            void'(mq.pop_front());
        end
        if (st_valid && ready && legal) mq.push_back(e);
        m_mis = st_valid && ready && !legal;
        check_all(tag);
    endtask

    task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f;
        st_addr   = a;
        st_data   = d;
    endtask

    int          pulses;
    logic        prev_wren;
    logic [2:0]  fsel [5];

    initial begin
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_funct3 = 3'd0;
        st_data   = 32'h0;
        ld_addr   = 32'h0;
        loading   = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Basic SW, then SB / SH lane placement
        store(3'd2, 32'h1000, 32'hDEAD_BEEF);
        cycle("t1_enq");
        st_valid = 1'b0;
        cycle("t1_iss");
        chk("t1_wren", 32'(wren), 32'd1);
        chk("t1_wraddr", wraddr, 32'h1000);
        chk("t1_wrstrb", 32'(wrstrb), 32'hF);
        chk("t1_wrdata", wrdata, 32'hDEAD_BEEF);
        cycle("t1_idle");

        store(3'd0, 32'h1003, 32'h0000_0012);
        cycle("t2_sb_enq");
        st_valid = 1'b0;
        cycle("t2_sb_iss");
        chk("t2_sb_strb", 32'(wrstrb), 32'h8);
        chk("t2_sb_data", wrdata, 32'h1212_1212);
        store(3'd1, 32'h1002, 32'h0000_ABCD);
        cycle("t2_sh_enq");
        st_valid = 1'b0;
        cycle("t2_sh_iss");
        chk("t2_sh_strb", 32'(wrstrb), 32'hC);
        chk("t2_sh_data", wrdata, 32'hABCD_ABCD);
        cycle("t2_idle");

        // Misaligned and illegal requests
        store(3'd1, 32'h1001, 32'h1);
        cycle("t3_sh_bad");
        chk("t3_sh_mis", 32'(st_misalign), 32'd1);
        store(3'd2, 32'h1002, 32'h2);
        cycle("t3_sw_bad");
        chk("t3_sw_mis", 32'(st_misalign), 32'd1);
        store(3'd3, 32'h1000, 32'h3);
        cycle("t3_f3_bad");
        st_valid = 1'b0;
        cycle("t3_after");
        chk("t3_mis_clear", 32'(st_misalign), 32'd0);
        chk("t3_no_wren", 32'(wren), 32'd0);
        chk("t3_empty", 32'(sq_empty), 32'd1);

        // Fill under back-pressure, then drain in order
        loading = 1'b1;
        for (int i = 0; i < 5; i++) begin
            store(3'd2, 32'h3000 + 32'(4 * i), 32'(i + 100));
            cycle("t4_fill");
        end
        chk("t4_full_ready", 32'(st_ready), 32'd0);
        st_valid  = 1'b0;
        loading   = 1'b0;
        pulses    = 0;
        prev_wren = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle("t4_drain");
            if (wren) begin
                chk("t4_order", wraddr, 32'h3000 + 32'(4 * pulses));
                chk("t4_not_consecutive", 32'(prev_wren), 32'd0);
                pulses++;
            end
            prev_wren = wren;
        end
        chk("t4_pulses", 32'(pulses), 32'd4);

        // Load alias detection
        loading = 1'b1;
        store(3'd2, 32'h2000, 32'h5555_5555);
        cycle("t5_enq");
        st_valid = 1'b0;
        ld_addr  = 32'h2004;
        #1;
`ifdef STORE_SQ_FWD_EN
        chk("t5_noalias", 32'(ld_conflict), 32'd0);
`else
        chk("t5_noalias", 32'(ld_conflict), 32'd1);
`endif
        ld_addr = 32'h2000;
        #1;
        chk("t5_alias", 32'(ld_conflict), 32'd1);
        loading = 1'b0;
        for (int c = 0; c < 4; c++) cycle("t5_drain");
        chk("t5_empty", 32'(sq_empty), 32'd1);
        chk("t5_conflict_clear", 32'(ld_conflict), 32'd0);

        // Reset mid-burst
        loading = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store(3'd2, 32'h4000 + 32'(4 * i), 32'hA0 + 32'(i));
            cycle("t6_fill");
        end
        st_valid = 1'b0;
        loading  = 1'b0;
        cycle("t6_iss");
        chk("t6_wren_before", 32'(wren), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("t6_rst_wren", 32'(wren), 32'd0);
        chk("t6_rst_wraddr", wraddr, 32'h0);
        chk("t6_rst_wrstrb", 32'(wrstrb), 32'h0);
        chk("t6_rst_wrdata", wrdata, 32'h0);
        chk("t6_rst_mis", 32'(st_misalign), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_empty_after", 32'(sq_empty), 32'd1);
        cycle("t6_idle");

        // Random traffic
        fsel[0] = 3'd0; fsel[1] = 3'd1; fsel[2] = 3'd2; fsel[3] = 3'd3; fsel[4] = 3'd5;
        for (int c = 0; c < 400; c++) begin
            st_valid  = ($urandom_range(0, 2) != 0);
            st_funct3 = ($urandom_range(0, 9) < 8) ? fsel[$urandom_range(0, 2)] : fsel[$urandom_range(3, 4)];
            st_addr   = 32'h5000 + 32'($urandom_range(0, 31));
            st_data   = $urandom;
            ld_addr   = 32'h5000 + 32'($urandom_range(0, 35));
            loading   = ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end
        st_valid = 1'b0;
        loading  = 1'b0;
        for (int c = 0; c < 12; c++) cycle("rnd_drain");
        chk("final_empty", 32'(sq_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
